seg7_capture_decode: RTL

SEG7_CAPTURE_DECODE -- requirements
Module: seg7_capture_decode

---
 rtl/seg7_capture_decode_pkg.sv | 35 +++
 rtl/seg7_to_hex.sv | 24 ++
 rtl/seg7_capture_decode.sv | 125 ++++++++++++
 3 files changed

// File: rtl/seg7_capture_decode_pkg.sv
// Shared display constants for the multiplexed 7-segment capture decoder:
// legal hex patterns, the blank pattern and digit-select helpers.
package seg7_capture_decode_pkg;

    localparam int NUM_DIGITS = 4;

    localparam logic [6:0] BLANK_PAT = 7'h7F;

    // Active-low patterns in g f e d c b a order, indexed by hex value
    localparam logic [6:0] HEX_PAT [16] = '{
        7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
        7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
    };

    typedef struct packed {
        logic [NUM_DIGITS-1:0] sel;
        logic [6:0]            seg;
    } sample_t;

    function automatic logic sel_is_valid(input logic [NUM_DIGITS-1:0] sel);
        return $countones(~sel) == 1;
    endfunction

    function automatic logic [1:0] sel_to_index(input logic [NUM_DIGITS-1:0] sel);
        logic [1:0] idx;
        idx = '0;
        for (int k = 0; k < NUM_DIGITS; k++) begin
            if (!sel[k]) begin
                idx = 2'(k);
            end
        end
        return idx;
    endfunction

endpackage

// File: rtl/seg7_to_hex.sv
// Combinational lookup from an active-low segment pattern to its hex value.
module seg7_to_hex
    import seg7_capture_decode_pkg::*;
(
    input  logic [6:0] seg_i,
    output logic [3:0] value_o,
    output logic       legal_o,
    output logic       blank_o
);

    always_comb begin
        value_o = '0;
        legal_o = 1'b0;
        for (int i = 0; i < 16; i++) begin
            if (seg_i == HEX_PAT[i]) begin
                value_o = 4'(i);
                legal_o = 1'b1;
            end
        end
    end

    assign blank_o = (seg_i == BLANK_PAT);

endmodule

// File: rtl/seg7_capture_decode.sv
// Captures a multiplexed 4-digit 7-segment display once each digit's
// pattern has been stable long enough, and decodes it to hex.
module seg7_capture_decode
    import seg7_capture_decode_pkg::*;
#(
    parameter int STABLE_CYCLES = 4
)
(
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic [0:6]  seg_i,
    input  logic [3:0]  dig_sel_i,
    output logic [15:0] digits_o,
    output logic [3:0]  valid_o,
    output logic [3:0]  blank_o,
    output logic [3:0]  err_o,
    output logic        upd_o,
    output logic [1:0]  upd_idx_o,
    output logic        frame_o
);

    sample_t     sample_q, sample_d;
    sample_t     prev_q, prev_d;
    logic [7:0]  cnt_q, cnt_d;
    logic [15:0] digits_q, digits_d;
    logic [3:0]  valid_q, valid_d;
    logic [3:0]  blank_q, blank_d;
    logic [3:0]  err_q, err_d;
    logic [3:0]  mask_q, mask_d;
    logic        upd_q, upd_d;
    logic [1:0]  upd_idx_q, upd_idx_d;
    logic        frame_q, frame_d;

    logic        sel_ok;
    logic        capture;
    logic [1:0]  cap_idx;
    logic [3:0]  mask_set;
    logic [3:0]  hex_value;
    logic        hex_legal;
    logic        hex_blank;

    seg7_to_hex u_seg7_to_hex (
        .seg_i   (sample_q.seg),
        .value_o (hex_value),
        .legal_o (hex_legal),
        .blank_o (hex_blank)
    );

    always_comb begin
        sample_d  = {dig_sel_i, seg_i};
        prev_d    = sample_q;
        sel_ok    = sel_is_valid(sample_q.sel);
        cap_idx   = sel_to_index(sample_q.sel);

        if (sel_ok && (sample_q == prev_q)) begin
            cnt_d = (cnt_q == 8'hFF) ? cnt_q : cnt_q + 8'd1;
        end else begin
            cnt_d = sel_ok ? 8'd1 : 8'd0;
        end

        // Comparing against cnt_q keeps a saturated counter from recapturing
        capture   = sel_ok && (cnt_d == 8'(STABLE_CYCLES)) && (cnt_q != cnt_d);

        digits_d  = digits_q;
        valid_d   = valid_q;
        blank_d   = blank_q;
        err_d     = err_q;
        mask_d    = mask_q;
        upd_d     = capture;
        upd_idx_d = upd_idx_q;
        frame_d   = 1'b0;
        mask_set  = mask_q | (4'b0001 << cap_idx);

        if (capture) begin
            upd_idx_d                      = cap_idx;
            digits_d[{cap_idx, 2'b00} +: 4] = hex_legal ? hex_value : 4'h0;
            valid_d[cap_idx]               = hex_legal;
            blank_d[cap_idx]               = hex_blank;
            err_d[cap_idx]                 = !hex_legal && !hex_blank;
            if (mask_set == 4'hF) begin
                frame_d = 1'b1;
                mask_d  = 4'h0;
            end else begin
                mask_d  = mask_set;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            sample_q  <= '1;
            prev_q    <= '1;
            cnt_q     <= '0;
            digits_q  <= '0;
            valid_q   <= '0;
            blank_q   <= '0;
            err_q     <= '0;
            mask_q    <= '0;
            upd_q     <= 1'b0;
            upd_idx_q <= '0;
            frame_q   <= 1'b0;
        end else begin
            sample_q  <= sample_d;
            prev_q    <= prev_d;
            cnt_q     <= cnt_d;
            digits_q  <= digits_d;
            valid_q   <= valid_d;
            blank_q   <= blank_d;
            err_q     <= err_d;
            mask_q    <= mask_d;
            upd_q     <= upd_d;
            upd_idx_q <= upd_idx_d;
            frame_q   <= frame_d;
        end
    end

    assign digits_o  = digits_q;
    assign valid_o   = valid_q;
    assign blank_o   = blank_q;
    assign err_o     = err_q;
    assign upd_o     = upd_q;
    assign upd_idx_o = upd_idx_q;
    assign frame_o   = frame_q;

endmodule
